// File: rtl/obstacle_scroller_if.sv
// Obstacle scroller bundle: game state and sprite widths in,
// per-slot positions, types, flags and event pulses out.
interface obstacle_scroller_if #(
    parameter int N_OBS = 3,
    parameter int XW    = 12
);
    logic [1:0]          gameState;
    logic [N_OBS*8-1:0]  obs_w;
    logic [N_OBS*XW-1:0] obs_x;
    logic [N_OBS-1:0]    obs_active;
    logic [N_OBS*2-1:0]  obs_type;
    logic                spawn_pulse;
    logic                retire_pulse;

    modport master (
        output gameState, obs_w,
        input  obs_x, obs_active, obs_type,
        input  spawn_pulse, retire_pulse
    );

    modport slave (
        input  gameState, obs_w,
        output obs_x, obs_active, obs_type,
        output spawn_pulse, retire_pulse
    );
endinterface

// File: rtl/obstacle_scroller.sv
// Per-frame obstacle scroller: moves active slots left, retires
// slots that leave the screen, spawns new ones on an LFSR-spaced gap.
module obstacle_scroller #(
    parameter int          N_OBS     = 3,
    parameter int          XW        = 12,
    parameter int          SCREEN_W  = 640,
    parameter int          DX        = 5,
    parameter int          MIN_GAP   = 160,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic FrameClk,
    input logic rst,
    obstacle_scroller_if.slave bus
);
    localparam logic [1:0]    GS_IDLE  = 2'b00;
    localparam logic [1:0]    GS_RUN   = 2'b01;
    localparam logic [15:0]   SEED     = (LFSR_SEED == 16'h0000) ?
                                         16'h0001 : LFSR_SEED;
    localparam logic [XW-1:0] X_SPAWN  = XW'(SCREEN_W);
    localparam logic [XW-1:0] STEP     = XW'(DX);
    localparam logic [XW-1:0] GAP_BASE = XW'(MIN_GAP);

    logic [N_OBS-1:0][XW-1:0] x_q, x_d;
    logic [N_OBS-1:0][1:0]    type_q, type_d;
    logic [N_OBS-1:0]         act_q, act_d;
    logic [XW-1:0]            gap_cnt_q, gap_cnt_d;
    logic [15:0]              lfsr_q, lfsr_d;
    logic                     spawn_q, spawn_d;
    logic                     retire_q, retire_d;

    logic [N_OBS-1:0] free_v;
    logic [N_OBS-1:0] spawn_sel;
    logic             do_spawn;
    logic [XW-1:0]    nx;
    logic [XW:0]      reach;
    logic [15:0]      lfsr_nx;
    logic             fb;

    // Lowest free slot as a one-hot mask (isolate lowest set bit).
    assign free_v    = ~act_q;
    assign spawn_sel = free_v & (~free_v + N_OBS'(1));
    assign do_spawn  = (gap_cnt_q == '0) && (|free_v);

    assign fb      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr_nx = {lfsr_q[14:0], fb};

    always_comb begin
        x_d       = x_q;
        type_d    = type_q;
        act_d     = act_q;
        gap_cnt_d = gap_cnt_q;
        lfsr_d    = lfsr_q;
        spawn_d   = 1'b0;
        retire_d  = 1'b0;
        nx        = '0;
        reach     = '0;
        case (bus.gameState)
            GS_RUN: begin
                for (int i = 0; i < N_OBS; i++) begin
                    if (act_q[i]) begin
                        nx     = x_q[i] - STEP;
                        x_d[i] = nx;
                        // Right edge after the move, one bit wider.
                        reach  = {nx[XW-1], nx} +
                                 {{(XW-7){1'b0}}, bus.obs_w[i*8 +: 8]};
                        if (reach[XW] || reach == '0) begin
                            act_d[i] = 1'b0;
                            retire_d = 1'b1;
                        end
                    end
                end
                if (do_spawn) begin
                    for (int i = 0; i < N_OBS; i++) begin
                        if (spawn_sel[i]) begin
                            x_d[i]    = X_SPAWN;
                            type_d[i] = lfsr_q[1:0];
                            act_d[i]  = 1'b1;
                        end
                    end
                    gap_cnt_d = GAP_BASE + {{(XW-7){1'b0}}, lfsr_q[8:2]};
                    spawn_d   = 1'b1;
                end else begin
                    gap_cnt_d = (gap_cnt_q > STEP) ? gap_cnt_q - STEP : '0;
                end
                lfsr_d = (lfsr_nx == 16'h0000) ? 16'h0001 : lfsr_nx;
            end
            GS_IDLE: begin
                x_d       = {N_OBS{X_SPAWN}};
                type_d    = '0;
                act_d     = '0;
                gap_cnt_d = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge FrameClk or posedge rst) begin
        if (rst) begin
            x_q       <= {N_OBS{X_SPAWN}};
            type_q    <= '0;
            act_q     <= '0;
            gap_cnt_q <= '0;
            lfsr_q    <= SEED;
            spawn_q   <= 1'b0;
            retire_q  <= 1'b0;
        end else begin
            x_q       <= x_d;
            type_q    <= type_d;
            act_q     <= act_d;
            gap_cnt_q <= gap_cnt_d;
            lfsr_q    <= lfsr_d;
            spawn_q   <= spawn_d;
            retire_q  <= retire_d;
        end
    end

    assign bus.obs_x        = x_q;
    assign bus.obs_type     = type_q;
    assign bus.obs_active   = act_q;
    assign bus.spawn_pulse  = spawn_q;
    assign bus.retire_pulse = retire_q;
endmodule

// File: tb/tb_obstacle_scroller.sv
// Bench for obstacle_scroller: directed table on default parameters,
// randomized run against a behavioural model on a short-gap instance.
module tb_obstacle_scroller;
    localparam int N  = 3;
    localparam int XW = 12;
    localparam int GAP_B = 20;

    logic FrameClk = 1'b0;
    logic rst = 1'b1;
    always #5 FrameClk = ~FrameClk;

    obstacle_scroller_if #(.N_OBS(N), .XW(XW)) ifa ();
    obstacle_scroller_if #(.N_OBS(N), .XW(XW)) ifb ();

    obstacle_scroller dut_a (
        .FrameClk(FrameClk),
        .rst(rst),
        .bus(ifa)
    );

    obstacle_scroller #(
        .MIN_GAP(GAP_B),
        .LFSR_SEED(16'h0000)
    ) dut_b (
        .FrameClk(FrameClk),
        .rst(rst),
        .bus(ifb)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int xa(input int i);
        return int'($signed(ifa.obs_x[i*XW +: XW]));
    endfunction

    function automatic int xb(input int i);
        return int'($signed(ifb.obs_x[i*XW +: XW]));
    endfunction

    // Behavioural model of dut_b
    int m_x[N];
    bit m_act[N];
    int m_typ[N];
    int m_gap;
    int m_lfsr;
    bit m_sp, m_rt;
    int mw[N];
    int hit_full = 0;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_x[i] = 640; m_act[i] = 0; m_typ[i] = 0;
        end
        m_gap = 0; m_lfsr = 1; m_sp = 0; m_rt = 0;
    endtask

    task automatic model_step(input logic [1:0] gs);
        int fr, nx, fb;
        bit sp;
        m_sp = 0;
        m_rt = 0;
        if (gs == 2'b00) begin
            for (int i = 0; i < N; i++) begin
                m_x[i] = 640; m_act[i] = 0; m_typ[i] = 0;
            end
            m_gap = 0;
        end else if (gs == 2'b01) begin
            fr = -1;
            for (int i = N - 1; i >= 0; i--)
                if (!m_act[i]) fr = i;
            sp = (m_gap == 0) && (fr >= 0);
            if (m_gap == 0 && fr < 0) hit_full++;
            for (int i = 0; i < N; i++) begin
                if (m_act[i]) begin
                    nx = m_x[i] - 5;
                    m_x[i] = nx;
                    if (nx + mw[i] <= 0) begin
                        m_act[i] = 0;
                        m_rt = 1;
                    end
                end
            end
            if (sp) begin
                m_x[fr] = 640;
                m_typ[fr] = m_lfsr % 4;
                m_act[fr] = 1;
                m_gap = GAP_B + (m_lfsr / 4) % 128;
                m_sp = 1;
            end else begin
                m_gap = (m_gap > 5) ? m_gap - 5 : 0;
            end
            fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^
                  (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
            m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
            if (m_lfsr == 0) m_lfsr = 1;
        end
    endtask

    task automatic compare_b();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("b_x%0d", i), xb(i), m_x[i]);
            chk($sformatf("b_act%0d", i), ifb.obs_active[i], m_act[i]);
            chk($sformatf("b_typ%0d", i), ifb.obs_type[i*2 +: 2], m_typ[i]);
        end
        chk("b_spawn", ifb.spawn_pulse, m_sp);
        chk("b_retire", ifb.retire_pulse, m_rt);
        chk("b_gap", dut_b.gap_cnt_q, m_gap);
        chk("b_lfsr", dut_b.lfsr_q, m_lfsr);
    endtask

    task automatic drive_b(input logic [1:0] gs);
        ifb.gameState = gs;
        for (int i = 0; i < N; i++) begin
            mw[i] = $urandom_range(0, 60);
            ifb.obs_w[i*8 +: 8] = 8'(mw[i]);
        end
    endtask

    typedef struct {
        logic [1:0] gs;
        logic [2:0] act;
        bit         sp;
        bit         rt;
        int         x0;
        int         t0;
        int         gap;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [1:0] gs;
        int r;
        bit found;

        // slot0 spawns with lfsr=ACE1: type 1, gap 160+56
        tbl[0] = '{2'b01, 3'b001, 1, 0, 640, 1, 216};
        tbl[1] = '{2'b01, 3'b001, 0, 0, 635, 1, 211};
        tbl[2] = '{2'b01, 3'b001, 0, 0, 630, 1, 206};
        tbl[3] = '{2'b10, 3'b001, 0, 0, 630, 1, 206};
        tbl[4] = '{2'b11, 3'b001, 0, 0, 630, 1, 206};
        tbl[5] = '{2'b01, 3'b001, 0, 0, 625, 1, 201};
        tbl[6] = '{2'b00, 3'b000, 0, 0, 640, 0, 0};
        tbl[7] = '{2'b10, 3'b000, 0, 0, 640, 0, 0};

        ifa.gameState = 2'b01;
        ifa.obs_w = {N{8'd20}};
        ifb.gameState = 2'b00;
        ifb.obs_w = '0;

        #12;
        for (int i = 0; i < N; i++)
            chk($sformatf("rst_x%0d", i), xa(i), 640);
        chk("rst_act", ifa.obs_active, 0);
        chk("rst_type", ifa.obs_type, 0);
        chk("rst_gap", dut_a.gap_cnt_q, 0);
        chk("rst_lfsr", dut_a.lfsr_q, 16'hACE1);
        chk("rst_spawn", ifa.spawn_pulse, 0);
        chk("rst_retire", ifa.retire_pulse, 0);
        chk("rst_lfsr_seed0", dut_b.lfsr_q, 1);
        rst = 1'b0;

        foreach (tbl[k]) begin
            ifa.gameState = tbl[k].gs;
            @(posedge FrameClk);
            #1;
            chk($sformatf("t%0d_act", k), ifa.obs_active, tbl[k].act);
            chk($sformatf("t%0d_spawn", k), ifa.spawn_pulse, tbl[k].sp);
            chk($sformatf("t%0d_retire", k), ifa.retire_pulse, tbl[k].rt);
            chk($sformatf("t%0d_x0", k), xa(0), tbl[k].x0);
            chk($sformatf("t%0d_t0", k), ifa.obs_type[1:0], tbl[k].t0);
            chk($sformatf("t%0d_gap", k), dut_a.gap_cnt_q, tbl[k].gap);
        end

        // Retire of slot0 with w=20 entering at x=-15
        rst = 1'b1;
        #2;
        rst = 1'b0;
        ifa.gameState = 2'b01;
        found = 0;
        for (int f = 0; f < 400 && !found; f++) begin
            @(posedge FrameClk);
            #1;
            if (ifa.obs_active[0] && xa(0) == -15) found = 1;
        end
        chk("reach_x_m15", found, 1);
        @(posedge FrameClk);
        #1;
        chk("ret_x0", xa(0), -20);
        chk("ret_act0", ifa.obs_active[0], 0);
        chk("ret_pulse", ifa.retire_pulse, 1);
        @(posedge FrameClk);
        #1;
        chk("ret_pulse_drop", ifa.retire_pulse, 0);
        ifa.gameState = 2'b00;

        // Randomized run on the short-gap instance
        #2;
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
        for (int f = 0; f < 3000; f++) begin
            r = $urandom_range(0, 999);
            gs = (r < 970) ? 2'b01 : (r < 985) ? 2'b10 :
                 (r < 997) ? 2'b11 : 2'b00;
            drive_b(gs);
            @(posedge FrameClk);
            #1;
            model_step(gs);
            compare_b();
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                chk("mid_rst_act", ifb.obs_active, 0);
                chk("mid_rst_spawn", ifb.spawn_pulse, 0);
                chk("mid_rst_retire", ifb.retire_pulse, 0);
                for (int i = 0; i < N; i++)
                    chk($sformatf("mid_rst_x%0d", i), xb(i), 640);
                model_reset();
                #1;
                rst = 1'b0;
            end
        end

        // Freeze under OVER, then IDLE clears
        for (int f = 0; f < 30; f++) begin
            drive_b(2'b01);
            @(posedge FrameClk);
            #1;
            model_step(2'b01);
            compare_b();
        end
        for (int f = 0; f < 10; f++) begin
            drive_b(2'b10);
            @(posedge FrameClk);
            #1;
            model_step(2'b10);
            compare_b();
        end
        drive_b(2'b00);
        @(posedge FrameClk);
        #1;
        model_step(2'b00);
        chk("idle_act", ifb.obs_active, 0);
        for (int i = 0; i < N; i++)
            chk($sformatf("idle_x%0d", i), xb(i), 640);
        chk("idle_gap", dut_b.gap_cnt_q, 0);

        chk("full_seen", hit_full > 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/obstacle_scroller.md
OBSTACLE_SCROLLER -- requirements
Module: obstacle_scroller

Interface
REQ-001 Parameter N_OBS, default 3: number of obstacle slots; legal range 1..8.
REQ-002 Parameter XW, default 12: signed x-position width.
REQ-003 Parameter SCREEN_W, default 640: spawn x-coordinate.
REQ-004 Parameter DX, default 5: pixels moved per frame.
REQ-005 Parameter MIN_GAP, default 160: minimum spawn spacing, in pixels.
REQ-006 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value.
REQ-007 FrameClk  in  1  frame clock; all state updates on its rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 gameState  in  2  game state: 00 IDLE, 01 RUN, 10 OVER; 11 SHALL be treated as OVER.
REQ-010 obs_w  in  N_OBS*8  per-slot obstacle width in pixels, driven by the sprite lookup from obs_type.
REQ-011 obs_x  out  N_OBS*XW  per-slot signed left-edge x.
REQ-012 obs_active  out  N_OBS  slot-occupied flags.
REQ-013 obs_type  out  N_OBS*2  per-slot sprite select.
REQ-014 spawn_pulse  out  1  high for exactly one frame when a spawn occurs.
REQ-015 retire_pulse  out  1  high for one frame when one or more slots retire.

Function
REQ-016 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance once per frame in RUN only; an all-zero state SHALL be forced to 16'h0001.
REQ-017 gap_cnt (XW bits, unsigned) SHALL decrement by DX each RUN frame, saturating at 0.
REQ-018 RUN, active slot: x <= x - DX (signed, XW bits).
REQ-019 RUN, active slot where (x - DX + w) <= 0 (signed): active SHALL clear in that same update; x takes the new value; retire_pulse=1.
REQ-020 RUN, gap_cnt==0 and at least one free slot (evaluated at frame start): the lowest-index free slot SHALL load x=SCREEN_W, type=lfsr[1:0], active=1; spawn_pulse=1; gap_cnt <= MIN_GAP + lfsr[8:2].
REQ-021 A newly spawned slot SHALL NOT move in its spawn frame.
REQ-022 All slots full with gap_cnt==0: no spawn; gap_cnt holds 0; spawn_pulse=0; the spawn SHALL occur on the first frame a slot is free at frame start.
REQ-023 A slot retiring in frame k SHALL NOT be reused before frame k+1.
REQ-024 At most one spawn per frame.
REQ-025 IDLE: all active=0, x=SCREEN_W, type=0, gap_cnt=0, pulses=0; LFSR holds.
REQ-026 OVER: all registers frozen, pulses=0.
REQ-027 Pulses SHALL be registered outputs; default 0 in every frame without an event.

Reset
REQ-028 rst=1 asynchronously SHALL force: obs_x=SCREEN_W for every slot, obs_active=0, obs_type=0, gap_cnt=0, lfsr=LFSR_SEED (or 1 if LFSR_SEED=0), spawn_pulse=0, retire_pulse=0.
REQ-029 Reset asserted mid-RUN SHALL discard all slots immediately, with no pulse generated.

Verification (N_OBS=3, DX=5, MIN_GAP=160)
REQ-030 Assert rst -> obs_x={640,640,640}, obs_active=000, obs_type=0, gap_cnt=0, lfsr=ACE1, both pulses 0.
REQ-031 Release rst, gameState=01 -> frame 1: slot0 active, x=640, spawn_pulse=1, gap_cnt=160+lfsr[8:2]; frame 2: x=635, spawn_pulse=0.
REQ-032 Slot0 w=20, x=-15 entering a frame -> x=-20, active=0, retire_pulse=1; spawn may reuse slot0 no earlier than the next frame.
REQ-033 All 3 slots active, gap_cnt=0 -> no spawn while full; the frame after one slot retires, that slot spawns with x=640.
REQ-034 gameState 01->10 with slots at x={300,120,-5} -> values frozen for 10 frames; then 00 -> active=000, x=640 for all slots.
REQ-035 gameState 11 -> behaviour identical to OVER.
